// File: rtl/qoa_pkg.sv
// Shared constants and FSM state type for the QOA slice unpacker.
package qoa_pkg;

    localparam int QOA_LMS_BYTES   = 16;
    localparam int QOA_SLICE_BYTES = 8;
    localparam int QOA_SLICE_LEN   = 20;
    localparam int QOA_SF_W        = 4;
    localparam int QOA_Q_W         = 3;

    typedef enum logic {
        LOAD_LMS = 1'b0,
        COLLECT  = 1'b1
    } qoa_state_e;

endpackage

// File: rtl/qoa_slice_unpacker_if.sv
// Residual-code handshake between the unpacker (master) and the sample decoder (slave).
interface qoa_slice_unpacker_if;

    logic                         res_valid;
    logic                         res_ready;
    logic [qoa_pkg::QOA_SF_W-1:0] res_sf;
    logic [qoa_pkg::QOA_Q_W-1:0]  res_q;
    logic                         res_last;

    modport master (output res_valid, output res_sf, output res_q, output res_last, input res_ready);
    modport slave  (input res_valid, input res_sf, input res_q, input res_last, output res_ready);

endinterface

// File: rtl/qoa_slice_emitter.sv
// Emit buffer: walks one 64-bit slice out as a scalefactor plus twenty 3-bit codes.
module qoa_slice_emitter
    import qoa_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        load,
    input  logic [63:0] slice,
    input  logic        first,
    output logic        can_load,
    output logic        frame_start,
    qoa_slice_unpacker_if.master res_if
);

    localparam logic [4:0] LAST_K = 5'(QOA_SLICE_LEN - 1);

    logic [63:0] buf_q, buf_d;
    logic [4:0]  k_q, k_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        fs_q, fs_d;
    logic        accept;

    always_comb begin
        accept   = valid_q & res_if.res_ready;
        can_load = !valid_q | (accept & last_q);
        buf_d    = buf_q;
        k_d      = k_q;
        valid_d  = valid_q;
        last_d   = last_q;
        fs_d     = 1'b0;
        if (accept) begin
            if (last_q) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                // scalefactor stays parked in [63:60]; the next code slides up to [59:57]
                k_d    = k_q + 5'd1;
                last_d = (k_d == LAST_K);
                buf_d  = {buf_q[63:60], buf_q[56:0], 3'b000};
            end
        end
        if (load) begin
            buf_d   = slice;
            k_d     = 5'd0;
            valid_d = 1'b1;
            last_d  = (LAST_K == 5'd0);
            fs_d    = first;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            buf_q   <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            fs_q    <= fs_d;
        end
    end

    assign res_if.res_valid = valid_q;
    assign res_if.res_sf    = buf_q[63:60];
    assign res_if.res_q     = buf_q[59:57];
    assign res_if.res_last  = last_q;
    assign frame_start      = fs_q;

endmodule

// File: rtl/qoa_slice_unpacker.sv
// Byte-stream front end: loads per-frame LMS state, then gathers 64-bit slices for the emitter.
module qoa_slice_unpacker
    import qoa_pkg::*;
#(
    parameter int SLICES_PER_FRAME = 256,
    parameter int CNT_W            = 9
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        data_rdy,
    input  logic [7:0]  data_in,
    output logic        lms_wr_en,
    output logic [2:0]  lms_wr_idx,
    output logic [15:0] lms_wr_data,
    qoa_slice_unpacker_if.master res_if,
    output logic        frame_start,
    output logic        overflow
);

    qoa_state_e       state_q, state_d;
    logic [3:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]       prev_byte_q, prev_byte_d;
    logic             lms_wr_en_q, lms_wr_en_d;
    logic [2:0]       lms_wr_idx_q, lms_wr_idx_d;
    logic [15:0]      lms_wr_data_q, lms_wr_data_d;
    logic [63:0]      fill_buf_q, fill_buf_d;
    logic [2:0]       fill_cnt_q, fill_cnt_d;
    logic             fill_full_q, fill_full_d;
    logic [CNT_W-1:0] slice_cnt_q, slice_cnt_d;
    logic             first_q, first_d;
    logic             overflow_q, overflow_d;
    logic             can_load;
    logic             xfer;

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        prev_byte_d   = prev_byte_q;
        lms_wr_en_d   = 1'b0;
        lms_wr_idx_d  = lms_wr_idx_q;
        lms_wr_data_d = lms_wr_data_q;
        fill_buf_d    = fill_buf_q;
        fill_cnt_d    = fill_cnt_q;
        fill_full_d   = fill_full_q;
        slice_cnt_d   = slice_cnt_q;
        first_d       = first_q;
        overflow_d    = overflow_q;

        xfer = fill_full_q & can_load;
        if (xfer) begin
            fill_full_d = 1'b0;
            first_d     = 1'b0;
            slice_cnt_d = slice_cnt_q + 1'b1;
            if (state_q == COLLECT && slice_cnt_d == CNT_W'(SLICES_PER_FRAME)) begin
                state_d    = LOAD_LMS;
                byte_cnt_d = 4'd0;
            end
        end

        if (data_rdy) begin
            case (state_q)
                LOAD_LMS: begin
                    prev_byte_d = data_in;
                    byte_cnt_d  = byte_cnt_q + 4'd1;
                    if (byte_cnt_q[0]) begin
                        lms_wr_en_d   = 1'b1;
                        lms_wr_idx_d  = byte_cnt_q[3:1];
                        lms_wr_data_d = {prev_byte_q, data_in};
                    end
                    if (byte_cnt_q == 4'(QOA_LMS_BYTES - 1)) begin
                        state_d     = COLLECT;
                        slice_cnt_d = '0;
                        fill_cnt_d  = 3'd0;
                        first_d     = 1'b1;
                    end
                end
                COLLECT: begin
                    // a byte landing in the same cycle as a transfer goes into the freed buffer
                    if (fill_full_q && !xfer) begin
                        overflow_d = 1'b1;
                    end else begin
                        fill_buf_d = {fill_buf_q[55:0], data_in};
                        fill_cnt_d = fill_cnt_q + 3'd1;
                        if (fill_cnt_q == 3'(QOA_SLICE_BYTES - 1)) fill_full_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= LOAD_LMS;
            byte_cnt_q    <= '0;
            prev_byte_q   <= '0;
            lms_wr_en_q   <= 1'b0;
            lms_wr_idx_q  <= '0;
            lms_wr_data_q <= '0;
            fill_buf_q    <= '0;
            fill_cnt_q    <= '0;
            fill_full_q   <= 1'b0;
            slice_cnt_q   <= '0;
            first_q       <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            prev_byte_q   <= prev_byte_d;
            lms_wr_en_q   <= lms_wr_en_d;
            lms_wr_idx_q  <= lms_wr_idx_d;
            lms_wr_data_q <= lms_wr_data_d;
            fill_buf_q    <= fill_buf_d;
            fill_cnt_q    <= fill_cnt_d;
            fill_full_q   <= fill_full_d;
            slice_cnt_q   <= slice_cnt_d;
            first_q       <= first_d;
            overflow_q    <= overflow_d;
        end
    end

    qoa_slice_emitter u_emitter (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .load        (xfer),
        .slice       (fill_buf_q),
        .first       (first_q),
        .can_load    (can_load),
        .frame_start (frame_start),
        .res_if      (res_if)
    );

    assign lms_wr_en   = lms_wr_en_q;
    assign lms_wr_idx  = lms_wr_idx_q;
    assign lms_wr_data = lms_wr_data_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_qoa_slice_unpacker.sv
// Scoreboard bench for qoa_slice_unpacker: stimulus pushes expected LMS words and codes, a monitor pops them.
module tb_qoa_slice_unpacker;
    import qoa_pkg::*;

    localparam int SPF = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        data_rdy = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        lms_wr_en;
    logic [2:0]  lms_wr_idx;
    logic [15:0] lms_wr_data;
    logic        frame_start;
    logic        overflow;

    qoa_slice_unpacker_if res_if ();

    qoa_slice_unpacker #(.SLICES_PER_FRAME(SPF), .CNT_W(9)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .data_rdy    (data_rdy),
        .data_in     (data_in),
        .lms_wr_en   (lms_wr_en),
        .lms_wr_idx  (lms_wr_idx),
        .lms_wr_data (lms_wr_data),
        .res_if      (res_if),
        .frame_start (frame_start),
        .overflow    (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [3:0] sf;
        logic [2:0] q;
        logic       last;
        logic       first;
    } code_t;

    code_t       exp_q[$];
    logic [18:0] lms_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int outstanding = 0;
    int slice_in_frame = 0;
    int ready_mode = 0;   // 0: ready high, 1: ready low, 2: random
    bit fs_seen = 0;
    bit b2b_expect = 0;
    bit b2b_check = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    initial begin
        res_if.res_ready = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            case (ready_mode)
                0:       res_if.res_ready = 1'b1;
                1:       res_if.res_ready = 1'b0;
                default: res_if.res_ready = ($urandom_range(3, 0) != 0);
            endcase
        end
    end

    always @(negedge sys_clk) begin
        code_t       e;
        logic [18:0] le;
        bit          fs_ok;
        if (sys_rst_n) begin
            if (b2b_check) begin
                check("b2b_valid", 32'(res_if.res_valid), 32'd1);
                b2b_check = 0;
            end
            if (lms_wr_en) begin
                if (lms_q.size() == 0) check("lms_unexpected", 32'(lms_wr_en), 32'd0);
                else begin
                    le = lms_q.pop_front();
                    check("lms_idx", 32'(lms_wr_idx), 32'(le[18:16]));
                    check("lms_data", 32'(lms_wr_data), 32'(le[15:0]));
                end
            end
            if (frame_start) begin
                fs_ok = res_if.res_valid && (exp_q.size() > 0) && exp_q[0].first;
                check("frame_start_pos", 32'(fs_ok), 32'd1);
                fs_seen = 1;
            end
            if (res_if.res_valid) begin
                if (exp_q.size() == 0) check("valid_unexpected", 32'(res_if.res_valid), 32'd0);
                else begin
                    e = exp_q[0];
                    check("res_sf", 32'(res_if.res_sf), 32'(e.sf));
                    check("res_q", 32'(res_if.res_q), 32'(e.q));
                    check("res_last", 32'(res_if.res_last), 32'(e.last));
                    if (res_if.res_ready) begin
                        exp_q.delete(0);
                        if (e.first) begin
                            check("frame_start_seen", 32'(fs_seen), 32'd1);
                            fs_seen = 0;
                        end
                        if (e.last) begin
                            outstanding--;
                            if (b2b_expect) begin
                                b2b_check  = 1;
                                b2b_expect = 0;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit wait_ok);
        int t = 0;
        if (wait_ok) begin
            while (outstanding >= 2 && t < 5000) begin
                @(posedge sys_clk);
                t++;
            end
            if (outstanding >= 2) timeout_fail("wait_slot");
        end
        @(posedge sys_clk);
        #1;
        data_rdy = 1'b1;
        data_in  = b;
        @(posedge sys_clk);
        #1;
        data_rdy = 1'b0;
        repeat ($urandom_range(4, 2)) @(posedge sys_clk);
    endtask

    task automatic send_lms(input bit counting);
        logic [15:0] w;
        for (int i = 0; i < 8; i++) begin
            w = counting ? {8'(2 * i + 1), 8'(2 * i + 2)} : 16'($urandom);
            lms_q.push_back({3'(i), w});
            send_byte(w[15:8], 1);
            send_byte(w[7:0], 1);
        end
        slice_in_frame = 0;
    endtask

    task automatic send_slice(input logic [63:0] s, input bit kept, input bit wait_ok);
        code_t e;
        if (kept) begin
            for (int k = 0; k < 20; k++) begin
                e.sf    = s[63:60];
                e.q     = 3'((s >> (57 - 3 * k)) & 64'h7);
                e.last  = (k == 19);
                e.first = (slice_in_frame == 0) && (k == 0);
                exp_q.push_back(e);
            end
            slice_in_frame++;
        end
        for (int i = 0; i < 8; i++) begin
            send_byte(8'((s >> (56 - 8 * i)) & 64'hFF), wait_ok);
            if (!kept && i == 0) check("ovf_set", 32'(overflow), 32'd1);
        end
        if (kept) outstanding++;
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!res_if.res_valid && t < 2000) begin
            @(posedge sys_clk);
            t++;
        end
        if (!res_if.res_valid) timeout_fail("wait_valid");
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || lms_q.size() != 0) && t < 5000) begin
            @(posedge sys_clk);
            t++;
        end
        check("drain_codes", 32'(exp_q.size()), 32'd0);
        check("drain_lms", 32'(lms_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_lms_en", 32'(lms_wr_en), 32'd0);
        check("rst_lms_idx", 32'(lms_wr_idx), 32'd0);
        check("rst_lms_data", 32'(lms_wr_data), 32'd0);
        check("rst_valid", 32'(res_if.res_valid), 32'd0);
        check("rst_sf", 32'(res_if.res_sf), 32'd0);
        check("rst_q", 32'(res_if.res_q), 32'd0);
        check("rst_last", 32'(res_if.res_last), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        sys_rst_n = 1'b1;

        // LMS bytes 01..10, then the 0x5...7 slice and a backpressured slice
        ready_mode = 0;
        send_lms(1);
        send_slice(64'h5000_0000_0000_0007, 1, 1);
        drain();
        send_slice({$urandom, $urandom}, 1, 1);
        wait_valid();
        repeat (5) @(posedge sys_clk);
        ready_mode = 1;
        repeat (10) @(posedge sys_clk);
        ready_mode = 0;
        drain();

        // overlap: B queued behind a stalled A must follow with no bubble
        send_lms(0);
        ready_mode = 1;
        send_slice({$urandom, $urandom}, 1, 1);
        wait_valid();
        send_slice({$urandom, $urandom}, 1, 1);
        check("overlap_no_ovf", 32'(overflow), 32'd0);
        b2b_expect = 1;
        ready_mode = 0;
        drain();
        check("b2b_consumed", 32'(b2b_expect), 32'd0);

        // overflow: third slice arrives while both buffers are occupied
        send_lms(0);
        ready_mode = 1;
        send_slice({$urandom, $urandom}, 1, 1);
        send_slice({$urandom, $urandom}, 1, 1);
        check("ovf_before", 32'(overflow), 32'd0);
        send_slice({$urandom, $urandom}, 0, 0);
        repeat (5) @(posedge sys_clk);
        ready_mode = 0;
        drain();
        check("ovf_sticky", 32'(overflow), 32'd1);

        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            send_lms(0);
            for (int s = 0; s < SPF; s++) send_slice({$urandom, $urandom}, 1, 1);
        end
        drain();

        // async reset in the middle of a slice, then restart from LMS load
        ready_mode = 0;
        send_lms(0);
        send_slice({$urandom, $urandom}, 1, 1);
        wait_valid();
        repeat (3) @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(res_if.res_valid), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_lms_en", 32'(lms_wr_en), 32'd0);
        exp_q.delete();
        lms_q.delete();
        outstanding = 0;
        fs_seen = 0;
        repeat (2) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
        send_lms(0);
        send_slice({$urandom, $urandom}, 1, 1);
        send_slice({$urandom, $urandom}, 1, 1);
        drain();
        check("final_outstanding", 32'(outstanding), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
